mod1024_up_sequencer: RTL and testbench
=======================================

Name: mod1024_up_sequencer

Overview:
Loadable, handshaked up-counting bit-index sequencer for the scalar-multiply datapath. Issues WIDTH-bit indices from a programmed first index up to a programmed last index, wrapping modulo 2**WIDTH, and complements the free-running down-counting index source. Sits between the EC control FSM and any consumer that walks scalar bits LSB-first, for example right-to-left double-and-add or scalar word unpacking.

Parameters:
WIDTH, 10, index width; the index space is 0 .. 2**WIDTH-1 and wraps modulo 2**WIDTH.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin a sequence; sampled only in IDLE or DONE.
first_idx  input  WIDTH  first index to issue; captured when start is accepted.
last_idx  input  WIDTH  last index to issue, inclusive; captured when start is accepted.
abort  input  1  terminates any sequence; returns the block to IDLE next cycle.
idx  output  WIDTH  current index offered to the consumer.
idx_valid  output  1  idx is valid.
idx_ready  input  1  consumer accepts idx when idx_valid && idx_ready.
idx_last  output  1  high with idx_valid when idx == captured last_idx.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse after the final index is accepted.
count  output  WIDTH+1  number of indices accepted in the current or most recent sequence.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - idx=0, idx_valid=0, idx_last=0, busy=0, done=0, count=0.
  - Captured first_idx and last_idx registers = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and abort=0: capture first_idx and last_idx, set idx=first_idx and count=0, go to RUN.
  - idx_valid and busy assert in the cycle after start, so latency is 1.
- RUN:
  - idx_valid=1 and busy=1.
  - idx_last = (idx == captured last).
  - Handshake (valid && ready) with idx_last=0: idx <= idx+1 modulo 2**WIDTH, so 2**WIDTH-1 wraps to 0; count <= count+1.
  - Handshake with idx_last=1: count <= count+1, go to DONE, done=1 for exactly that next cycle, idx_valid=0.
  - No handshake: idx, idx_valid and idx_last hold stable; idx_valid never drops while ready is low.
  - start is ignored while in RUN.
- DONE:
  - Lasts one cycle; done=1, busy=0; idx holds its final value.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back sequences); otherwise go to IDLE.
- abort:
  - Highest priority in every state.
  - Next cycle: state=IDLE, idx_valid=0, busy=0, done=0; idx and count hold their values.
  - A handshake that coincides with abort does count; no done pulse is produced.
- Sequence length = ((last - first) mod 2**WIDTH) + 1, in the range 1 .. 2**WIDTH.
  - first==last issues exactly one index.
  - last==first-1 (mod) issues all 2**WIDTH indices; count reaches 2**WIDTH, hence the WIDTH+1 bits.
- start and abort in the same cycle: abort wins and the start is dropped.
- rst_n asserted mid-sequence: immediate return to the reset values; no done pulse.
- All outputs are registered; there is no combinational path from idx_ready to idx_valid.

Decomposition:
- Shared package (ec_ctrl_pkg): state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2, and the default index width constant (10).
- One natural sub-module: mod1024_up_counter, a loadable, enabled, wrap-around WIDTH-bit up counter with a synchronous load.
  - Same async active-low reset.
  - Instantiated for idx; count stays in the parent.

Test Plan:
- Basic run: first=5, last=8, idx_ready=1 continuously -> idx 5,6,7,8 on four consecutive cycles starting 1 cycle after start; idx_last only on 8; done pulse one cycle after 8 is accepted; count=4.
- Wrap-around: first=1022, last=1 -> idx 1022,1023,0,1; count=4; done once.
- Backpressure: first=0, last=2, idx_ready toggling 1,0,0,1,0,1 -> idx_valid stays high, idx holds during ready=0, sequence 0,1,2 with no skips or repeats.
- Full range and single index:
  - first=0, last=1023 -> 1024 indices, count=1024.
  - first=last=300 -> one index with idx_last=1, count=1.
- Abort and start collision:
  - abort raised after 2 handshakes of 0..9 -> IDLE next cycle, count=2, no done.
  - start and abort in the same cycle -> block stays IDLE.
- Reset and back-to-back:
  - rst_n pulsed low mid-run -> all outputs go to zero asynchronously.
  - start asserted during the DONE cycle -> new sequence begins with no IDLE gap.

Source files
------------

// File: rtl/mod1024_up_sequencer_pkg.sv
// Purpose: shared constants and state encoding for the index sequencer and its sub-blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ec_ctrl_pkg;

  // Default index width; the index space is 0 .. 2**IDX_WIDTH-1.
  localparam int IDX_WIDTH = 10;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mod1024_up_sequencer_if.sv
// Purpose: control and index-stream bundle between the EC control FSM, the sequencer and the consumer.
// Latency: n/a (wiring only).
// Backpressure: idx_valid/idx_ready handshake; the sequencer side is the master.
interface mod1024_up_sequencer_if
  import ec_ctrl_pkg::*;
#(
  parameter int WIDTH = IDX_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] first_idx;
  logic [WIDTH-1:0] last_idx;
  logic             abort;
  logic [WIDTH-1:0] idx;
  logic             idx_valid;
  logic             idx_ready;
  logic             idx_last;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   count;

  // Sequencer side: takes commands and ready, produces the index stream and status.
  modport master (
    input  start, first_idx, last_idx, abort, idx_ready,
    output idx, idx_valid, idx_last, busy, done, count
  );

  // Controller/consumer side.
  modport slave (
    output start, first_idx, last_idx, abort, idx_ready,
    input  idx, idx_valid, idx_last, busy, done, count
  );

endinterface

// File: rtl/mod1024_up_sequencer_up_counter.sv
// Purpose: loadable, enabled WIDTH-bit up counter that wraps modulo 2**WIDTH.
// Latency: load and increment take effect on the next rising edge.
// Backpressure: none; the parent gates en with its handshake.
module mod1024_up_counter
  import ec_ctrl_pkg::*;
#(
  parameter int WIDTH = IDX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Load wins over increment; the add overflows naturally, giving the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod1024_up_sequencer.sv
// Purpose: issues indices first..last (inclusive, wrapping mod 2**WIDTH) over a valid/ready stream.
// Latency: first index is valid one cycle after start is accepted; done pulses one cycle after the last handshake.
// Backpressure: idx/idx_valid/idx_last hold while idx_ready is low; all outputs are registered.
module mod1024_up_sequencer
  import ec_ctrl_pkg::*;
#(
  parameter int WIDTH = IDX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mod1024_up_sequencer_if.master bus
);

  seq_state_t       state;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] idx_q;
  logic [WIDTH-1:0] idx_inc;
  logic             valid_q;
  logic             last_flag_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH:0]   count_q;

  logic             hs;
  logic             accept_start;
  logic             advance;

  // valid_q is only ever high in RUN, so hs implies RUN.
  assign hs           = valid_q && bus.idx_ready;
  assign accept_start = bus.start && !bus.abort && ((state == IDLE) || (state == DONE));
  // Abort freezes idx even when it coincides with a handshake.
  assign advance      = (state == RUN) && hs && !last_flag_q && !bus.abort;
  assign idx_inc      = idx_q + WIDTH'(1);

  // The load of first_idx into the idx counter is the capture of the first index.
  mod1024_up_counter #(
    .WIDTH (WIDTH)
  ) u_idx_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_start),
    .load_val (bus.first_idx),
    .en       (advance),
    .q        (idx_q)
  );

  // Control FSM with all status outputs registered; abort overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_q      <= '0;
      valid_q     <= 1'b0;
      last_flag_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else if (bus.abort) begin
      if (hs) begin
        count_q <= count_q + (WIDTH+1)'(1);
      end
      state       <= IDLE;
      valid_q     <= 1'b0;
      last_flag_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state       <= RUN;
            last_q      <= bus.last_idx;
            count_q     <= '0;
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            last_flag_q <= (bus.first_idx == bus.last_idx);
          end else begin
            state       <= IDLE;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            last_flag_q <= 1'b0;
          end
        end
        RUN: begin
          if (hs) begin
            count_q <= count_q + (WIDTH+1)'(1);
            if (last_flag_q) begin
              state       <= DONE;
              valid_q     <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              last_flag_q <= 1'b0;
            end else begin
              // Look ahead at the index that will be offered next.
              last_flag_q <= (idx_inc == last_q);
            end
          end
        end
        default: begin
          state       <= IDLE;
          valid_q     <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          last_flag_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.idx       = idx_q;
  assign bus.idx_valid = valid_q;
  assign bus.idx_last  = last_flag_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_mod1024_up_sequencer.sv
// Purpose: self-checking bench for mod1024_up_sequencer (vector table, hand sequences, random vs model).
// Latency: n/a.
// Backpressure: drives idx_ready with fixed patterns and random values.
module tb_mod1024_up_sequencer;

  localparam int W = 10;
  localparam int N = 1024;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mod1024_up_sequencer_if #(.WIDTH(W)) sif ();

  mod1024_up_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: tracks how many indices of the current sequence were accepted.
  bit m_active;
  bit m_done;
  int m_first;
  int m_len;
  int m_k;
  int m_idx;

  typedef struct {
    int first;
    int last;
    int mode;     // 0: ready always high, 1: pattern 1,0,0,1,0,1, 2: random
    int exp_len;
  } vec_t;

  vec_t vecs[6];
  bit   pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_first  = 0;
    m_len    = 1;
    m_k      = 0;
    m_idx    = 0;
  endtask

  task automatic model_step(input bit s, input int f, input int l, input bit ab, input bit rdy);
    bit hs;
    hs     = m_active && rdy;
    m_done = 1'b0;
    if (ab) begin
      if (hs) m_k++;
      m_active = 1'b0;
    end else if (m_active) begin
      if (hs) begin
        m_k++;
        if (m_k == m_len) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (s) begin
      m_active = 1'b1;
      m_first  = f;
      m_len    = ((l - f + N) % N) + 1;
      m_k      = 0;
    end
    if (m_active) m_idx = (m_first + m_k) % N;
  endtask

  // One clock: advance the model with the inputs the DUT samples, then compare all outputs.
  task automatic tick();
    model_step(sif.start, int'(sif.first_idx), int'(sif.last_idx), sif.abort, sif.idx_ready);
    @(posedge clk);
    #1;
    chk("idx_valid", int'(sif.idx_valid), int'(m_active));
    chk("busy",      int'(sif.busy),      int'(m_active));
    chk("done",      int'(sif.done),      int'(m_done));
    chk("idx_last",  int'(sif.idx_last),  (m_active && (m_k == m_len - 1)) ? 1 : 0);
    chk("idx",       int'(sif.idx),       m_idx);
    chk("count",     int'(sif.count),     m_k);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_idx"},       int'(sif.idx),       0);
    chk({tag, "_idx_valid"}, int'(sif.idx_valid), 0);
    chk({tag, "_idx_last"},  int'(sif.idx_last),  0);
    chk({tag, "_busy"},      int'(sif.busy),      0);
    chk({tag, "_done"},      int'(sif.done),      0);
    chk({tag, "_count"},     int'(sif.count),     0);
  endtask

  task automatic run_vec(input vec_t v);
    int q[$];
    bit seen;
    int budget;
    int j;
    sif.first_idx = W'(v.first);
    sif.last_idx  = W'(v.last);
    sif.idx_ready = 1'b0;
    sif.start     = 1'b1;
    tick();
    sif.start = 1'b0;
    seen   = 1'b0;
    budget = 0;
    j      = 0;
    while (!seen && budget < 4000) begin
      case (v.mode)
        0:       sif.idx_ready = 1'b1;
        1:       sif.idx_ready = pat[j % 6];
        default: sif.idx_ready = 1'($urandom_range(0, 1));
      endcase
      j++;
      if (sif.idx_valid && sif.idx_ready) q.push_back(int'(sif.idx));
      tick();
      if (sif.done) seen = 1'b1;
      budget++;
    end
    chk("vec_done_seen", int'(seen), 1);
    chk("vec_len", q.size(), v.exp_len);
    chk("vec_count", int'(sif.count), v.exp_len);
    for (int i = 0; i < q.size(); i++) chk("vec_idx_order", q[i], (v.first + i) % N);
    sif.idx_ready = 1'b0;
    tick();
    chk("vec_done_one_cycle", int'(sif.done), 0);
  endtask

  initial begin
    vecs[0] = '{first: 5,    last: 8,    mode: 0, exp_len: 4};
    vecs[1] = '{first: 1022, last: 1,    mode: 0, exp_len: 4};
    vecs[2] = '{first: 0,    last: 2,    mode: 1, exp_len: 3};
    vecs[3] = '{first: 0,    last: 1023, mode: 0, exp_len: 1024};
    vecs[4] = '{first: 300,  last: 300,  mode: 0, exp_len: 1};
    vecs[5] = '{first: 10,   last: 9,    mode: 2, exp_len: 1024};

    sif.start     = 1'b0;
    sif.abort     = 1'b0;
    sif.idx_ready = 1'b0;
    sif.first_idx = '0;
    sif.last_idx  = '0;
    rst_n         = 1'b0;
    model_reset();
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic run with explicit expectations: 5,6,7,8 then a done pulse.
    sif.first_idx = W'(5);
    sif.last_idx  = W'(8);
    sif.idx_ready = 1'b1;
    sif.start     = 1'b1;
    tick();
    sif.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("basic_idx", int'(sif.idx), 5 + k);
      chk("basic_valid", int'(sif.idx_valid), 1);
      chk("basic_last", int'(sif.idx_last), (k == 3) ? 1 : 0);
      tick();
    end
    chk("basic_done", int'(sif.done), 1);
    chk("basic_count", int'(sif.count), 4);
    chk("basic_busy", int'(sif.busy), 0);
    sif.idx_ready = 1'b0;
    tick();
    chk("basic_done_drop", int'(sif.done), 0);

    // Table of whole sequences.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort after two handshakes of 0..9.
    sif.first_idx = W'(0);
    sif.last_idx  = W'(9);
    sif.idx_ready = 1'b1;
    sif.start     = 1'b1;
    tick();
    sif.start = 1'b0;
    tick();
    tick();
    sif.idx_ready = 1'b0;
    sif.abort     = 1'b1;
    tick();
    sif.abort = 1'b0;
    chk("abort_busy", int'(sif.busy), 0);
    chk("abort_valid", int'(sif.idx_valid), 0);
    chk("abort_done", int'(sif.done), 0);
    chk("abort_count", int'(sif.count), 2);
    chk("abort_idx", int'(sif.idx), 2);
    tick();
    chk("abort_no_done", int'(sif.done), 0);

    // Abort coinciding with a handshake still counts that index.
    sif.idx_ready = 1'b1;
    sif.start     = 1'b1;
    tick();
    sif.start = 1'b0;
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    chk("abort_hs_count", int'(sif.count), 1);
    chk("abort_hs_done", int'(sif.done), 0);
    sif.idx_ready = 1'b0;
    tick();

    // start and abort together: stays idle.
    sif.first_idx = W'(50);
    sif.last_idx  = W'(60);
    sif.start     = 1'b1;
    sif.abort     = 1'b1;
    tick();
    sif.start = 1'b0;
    sif.abort = 1'b0;
    chk("coll_busy", int'(sif.busy), 0);
    chk("coll_valid", int'(sif.idx_valid), 0);
    chk("coll_count", int'(sif.count), 1);
    tick();
    chk("coll_still_idle", int'(sif.busy), 0);

    // Back-to-back: start in the DONE cycle.
    sif.first_idx = W'(3);
    sif.last_idx  = W'(4);
    sif.idx_ready = 1'b1;
    sif.start     = 1'b1;
    tick();
    sif.start = 1'b0;
    tick();
    tick();
    chk("b2b_done", int'(sif.done), 1);
    sif.first_idx = W'(7);
    sif.last_idx  = W'(7);
    sif.start     = 1'b1;
    tick();
    sif.start = 1'b0;
    chk("b2b_busy", int'(sif.busy), 1);
    chk("b2b_idx", int'(sif.idx), 7);
    chk("b2b_last", int'(sif.idx_last), 1);
    chk("b2b_count", int'(sif.count), 0);
    tick();
    chk("b2b_done2", int'(sif.done), 1);
    chk("b2b_count2", int'(sif.count), 1);
    sif.idx_ready = 1'b0;
    tick();

    // Asynchronous reset in the middle of a run.
    sif.first_idx = W'(100);
    sif.last_idx  = W'(200);
    sif.idx_ready = 1'b1;
    sif.start     = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sif.idx_ready = 1'b0;
    tick();
    chk("arst_no_done", int'(sif.done), 0);

    // Random sequences with random ready, stray starts and occasional aborts.
    for (int s = 0; s < 40; s++) begin
      int f;
      int len;
      int b;
      f   = int'($urandom_range(0, N - 1));
      len = int'($urandom_range(1, 40));
      sif.first_idx = W'(f);
      sif.last_idx  = W'((f + len - 1) % N);
      sif.idx_ready = 1'($urandom_range(0, 1));
      sif.start     = 1'b1;
      tick();
      b = 0;
      while (m_active && b < 400) begin
        sif.idx_ready = ($urandom_range(0, 3) != 0);
        sif.abort     = ($urandom_range(0, 59) == 0);
        sif.start     = ($urandom_range(0, 7) == 0);
        sif.first_idx = W'($urandom_range(0, N - 1));
        sif.last_idx  = W'($urandom_range(0, N - 1));
        tick();
        b++;
      end
      sif.start = 1'b0;
      sif.abort = 1'b0;
      chk("rnd_terminated", int'(m_active), 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
